// File: rtl/csr_req_sequencer.sv
// CSR request sequencer: latches one committed CSR/system request, issues it to
// the CSR file, handles replay back-off, WFI stall and response timeout, and
// returns the result to writeback as a single-cycle pulse.

package csr_req_sequencer_pkg;

    typedef struct packed {
        logic [11:0] addr;
        logic [2:0]  cmd;
        logic [63:0] data;
        logic [63:0] pc;
    } req_cpu_csr_t;

endpackage

module csr_req_sequencer
    import csr_req_sequencer_pkg::*;
#(
    parameter int unsigned REPLAY_DELAY  = 4,
    parameter int unsigned RESP_TIMEOUT  = 64,
    parameter logic [63:0] TIMEOUT_CAUSE = 64'h2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         req_valid_i,
    input  req_cpu_csr_t req_i,
    input  logic         flush_i,
    output logic         csr_req_valid_o,
    output req_cpu_csr_t csr_req_o,
    input  logic         csr_resp_valid_i,
    input  logic [63:0]  csr_rdata_i,
    input  logic         csr_replay_i,
    input  logic         csr_stall_i,
    input  logic         csr_xcpt_i,
    input  logic [63:0]  csr_xcpt_cause_i,
    input  logic         csr_eret_i,
    input  logic [63:0]  csr_evec_i,
    output logic         commit_stall_o,
    output logic         wb_valid_o,
    output logic [63:0]  wb_rdata_o,
    output logic         xcpt_o,
    output logic [63:0]  xcpt_cause_o,
    output logic         eret_o,
    output logic [63:0]  evec_o
);

    localparam int unsigned BackoffW = (REPLAY_DELAY > 1) ? $clog2(REPLAY_DELAY) : 1;
    localparam int unsigned TimeoutW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [BackoffW-1:0] BackoffInit = BackoffW'(REPLAY_DELAY - 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StBackoff,
        StStall,
        StDone
    } state_t;

    state_t              state_q;
    req_cpu_csr_t        req_q;
    logic [BackoffW-1:0] backoff_cnt_q;
    logic [TimeoutW-1:0] timeout_cnt_q;
    logic                flush_pend_q;
    logic                req_strobe_q;
    logic                wb_valid_q;
    logic [63:0]         rdata_q;
    logic                xcpt_q;
    logic [63:0]         cause_q;
    logic                eret_q;
    logic [63:0]         evec_q;

    // Sequencer FSM; strobes are set on entry to ISSUE/DONE so they last exactly one cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= StIdle;
            req_q         <= '0;
            backoff_cnt_q <= '0;
            timeout_cnt_q <= '0;
            flush_pend_q  <= 1'b0;
            req_strobe_q  <= 1'b0;
            wb_valid_q    <= 1'b0;
            rdata_q       <= '0;
            xcpt_q        <= 1'b0;
            cause_q       <= '0;
            eret_q        <= 1'b0;
            evec_q        <= '0;
        end else begin
            req_strobe_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    backoff_cnt_q <= '0;
                    timeout_cnt_q <= '0;
                    flush_pend_q  <= 1'b0;
                    if (req_valid_i && !flush_i) begin
                        req_q        <= req_i;
                        req_strobe_q <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    timeout_cnt_q <= '0;
                    state_q       <= flush_i ? StIdle : StWait;
                end
                StWait: begin
                    if (csr_resp_valid_i) begin
                        // A flushed instruction still has its response consumed, then is dropped.
                        if (flush_pend_q || flush_i) begin
                            state_q <= StIdle;
                        end else if (csr_xcpt_i) begin
                            rdata_q    <= '0;
                            xcpt_q     <= 1'b1;
                            cause_q    <= csr_xcpt_cause_i;
                            eret_q     <= 1'b0;
                            evec_q     <= csr_evec_i;
                            wb_valid_q <= 1'b1;
                            state_q    <= StDone;
                        end else if (csr_replay_i) begin
                            backoff_cnt_q <= BackoffInit;
                            state_q       <= StBackoff;
                        end else if (csr_stall_i) begin
                            state_q <= StStall;
                        end else begin
                            rdata_q    <= csr_rdata_i;
                            xcpt_q     <= 1'b0;
                            cause_q    <= '0;
                            eret_q     <= csr_eret_i;
                            evec_q     <= csr_evec_i;
                            wb_valid_q <= 1'b1;
                            state_q    <= StDone;
                        end
                    end else if (timeout_cnt_q == TimeoutLast) begin
                        if (flush_pend_q || flush_i) begin
                            state_q <= StIdle;
                        end else begin
                            rdata_q    <= '0;
                            xcpt_q     <= 1'b1;
                            cause_q    <= TIMEOUT_CAUSE;
                            eret_q     <= 1'b0;
                            evec_q     <= '0;
                            wb_valid_q <= 1'b1;
                            state_q    <= StDone;
                        end
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + TimeoutW'(1);
                        if (flush_i) begin
                            flush_pend_q <= 1'b1;
                        end
                    end
                end
                StBackoff: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (backoff_cnt_q == '0) begin
                        req_strobe_q <= 1'b1;
                        state_q      <= StIssue;
                    end else begin
                        backoff_cnt_q <= backoff_cnt_q - BackoffW'(1);
                    end
                end
                StStall: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (!csr_stall_i) begin
                        rdata_q    <= '0;
                        xcpt_q     <= 1'b0;
                        cause_q    <= '0;
                        eret_q     <= 1'b0;
                        evec_q     <= '0;
                        wb_valid_q <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    // The instruction is already resolved, so a flush here does not cancel it.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Commit is held while a request is pending; in IDLE it mirrors the incoming request.
    always_comb begin
        commit_stall_o = 1'b1;
        if (state_q == StIdle) begin
            commit_stall_o = req_valid_i;
        end else if (state_q == StDone) begin
            commit_stall_o = 1'b0;
        end
    end

    assign csr_req_valid_o = req_strobe_q;
    assign csr_req_o       = req_q;
    assign wb_valid_o      = wb_valid_q;
    assign wb_rdata_o      = rdata_q;
    assign xcpt_o          = xcpt_q;
    assign xcpt_cause_o    = cause_q;
    assign eret_o          = eret_q;
    assign evec_o          = evec_q;

endmodule

// File: tb/tb_csr_req_sequencer.sv
// Scoreboard bench for csr_req_sequencer: stimulus pushes expected issue pulses and
// writeback results (with their cycle), a negedge monitor pops and compares.

module tb_csr_req_sequencer;
    import csr_req_sequencer_pkg::*;

    typedef struct {
        int           cyc;
        req_cpu_csr_t req;
    } iss_exp_t;

    typedef struct {
        int          cyc;
        logic [4:0]  mask;
        logic [63:0] rdata;
        logic        xcpt;
        logic [63:0] cause;
        logic        eret;
        logic [63:0] evec;
    } wb_exp_t;

    localparam logic [4:0] MRdata = 5'b00001;
    localparam logic [4:0] MXcpt  = 5'b00010;
    localparam logic [4:0] MCause = 5'b00100;
    localparam logic [4:0] MEret  = 5'b01000;
    localparam logic [4:0] MEvec  = 5'b10000;
    localparam logic [4:0] MNorm  = MRdata | MXcpt | MEret | MEvec;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         req_valid = 1'b0;
    req_cpu_csr_t req = '0;
    logic         flush = 1'b0;
    logic         csr_req_valid;
    req_cpu_csr_t csr_req;
    logic         resp_valid = 1'b0;
    logic [63:0]  rdata_in = '0;
    logic         replay_in = 1'b0;
    logic         stall_in = 1'b0;
    logic         xcpt_in = 1'b0;
    logic [63:0]  cause_in = '0;
    logic         eret_in = 1'b0;
    logic [63:0]  evec_in = '0;
    logic         commit_stall;
    logic         wb_valid;
    logic [63:0]  wb_rdata;
    logic         xcpt;
    logic [63:0]  xcpt_cause;
    logic         eret;
    logic [63:0]  evec;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    iss_exp_t iss_q[$];
    wb_exp_t  wb_q[$];
    iss_exp_t ie;
    wb_exp_t  we;

    csr_req_sequencer #(
        .REPLAY_DELAY (4),
        .RESP_TIMEOUT (64),
        .TIMEOUT_CAUSE(64'h2)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .req_valid_i     (req_valid),
        .req_i           (req),
        .flush_i         (flush),
        .csr_req_valid_o (csr_req_valid),
        .csr_req_o       (csr_req),
        .csr_resp_valid_i(resp_valid),
        .csr_rdata_i     (rdata_in),
        .csr_replay_i    (replay_in),
        .csr_stall_i     (stall_in),
        .csr_xcpt_i      (xcpt_in),
        .csr_xcpt_cause_i(cause_in),
        .csr_eret_i      (eret_in),
        .csr_evec_i      (evec_in),
        .commit_stall_o  (commit_stall),
        .wb_valid_o      (wb_valid),
        .wb_rdata_o      (wb_rdata),
        .xcpt_o          (xcpt),
        .xcpt_cause_o    (xcpt_cause),
        .eret_o          (eret),
        .evec_o          (evec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every issue / writeback pulse must match the head of its queue.
    always @(negedge clk) begin
        if (csr_req_valid) begin
            if (iss_q.size() == 0) begin
                chk("unexpected_issue", 192'(1), 192'(0));
            end else begin
                ie = iss_q.pop_front();
                chk("issue_cycle", 192'(cyc), 192'(ie.cyc));
                chk("issue_req", 192'(csr_req), 192'(ie.req));
            end
        end
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                chk("unexpected_wb", 192'(1), 192'(0));
            end else begin
                we = wb_q.pop_front();
                chk("wb_cycle", 192'(cyc), 192'(we.cyc));
                chk("wb_commit_stall", 192'(commit_stall), 192'(0));
                if (we.mask[0]) chk("wb_rdata", 192'(wb_rdata), 192'(we.rdata));
                if (we.mask[1]) chk("wb_xcpt", 192'(xcpt), 192'(we.xcpt));
                if (we.mask[2]) chk("wb_cause", 192'(xcpt_cause), 192'(we.cause));
                if (we.mask[3]) chk("wb_eret", 192'(eret), 192'(we.eret));
                if (we.mask[4]) chk("wb_evec", 192'(evec), 192'(we.evec));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic exp_iss(input int c, input req_cpu_csr_t r);
        iss_exp_t e;
        e.cyc = c;
        e.req = r;
        iss_q.push_back(e);
    endtask

    task automatic exp_wb(input int c, input logic [4:0] m, input logic [63:0] rd,
                          input logic xc, input logic [63:0] ca, input logic er,
                          input logic [63:0] ev);
        wb_exp_t e;
        e.cyc = c;
        e.mask = m;
        e.rdata = rd;
        e.xcpt = xc;
        e.cause = ca;
        e.eret = er;
        e.evec = ev;
        wb_q.push_back(e);
    endtask

    // Present a request in IDLE; the issue pulse is expected on the following cycle.
    task automatic send_req(input req_cpu_csr_t r, output int ki);
        req_valid = 1'b1;
        req = r;
        ki = cyc + 1;
        exp_iss(ki, r);
        @(negedge clk);
        chk("idle_commit_stall", 192'(commit_stall), 192'(1));
        wait_to(ki);
        req_valid = 1'b0;
        req = '0;
    endtask

    // Drive a one-cycle response at cycle c; csr_stall_i is left for the caller to drop.
    task automatic do_resp(input int c, input logic [63:0] rd, input logic rp, input logic st,
                           input logic xc, input logic [63:0] ca, input logic er,
                           input logic [63:0] ev);
        wait_to(c);
        resp_valid = 1'b1;
        rdata_in = rd;
        replay_in = rp;
        stall_in = st;
        xcpt_in = xc;
        cause_in = ca;
        eret_in = er;
        evec_in = ev;
        wait_to(c + 1);
        resp_valid = 1'b0;
        rdata_in = '0;
        replay_in = 1'b0;
        xcpt_in = 1'b0;
        cause_in = '0;
        eret_in = 1'b0;
        evec_in = '0;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        chk({tag, "_csr_req_valid"}, 192'(csr_req_valid), 192'(0));
        chk({tag, "_csr_req"}, 192'(csr_req), 192'(0));
        chk({tag, "_commit_stall"}, 192'(commit_stall), 192'(0));
        chk({tag, "_wb_valid"}, 192'(wb_valid), 192'(0));
        chk({tag, "_wb_rdata"}, 192'(wb_rdata), 192'(0));
        chk({tag, "_xcpt"}, 192'(xcpt), 192'(0));
        chk({tag, "_xcpt_cause"}, 192'(xcpt_cause), 192'(0));
        chk({tag, "_eret"}, 192'(eret), 192'(0));
        chk({tag, "_evec"}, 192'(evec), 192'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        req_cpu_csr_t r;
        int ki;
        int kj;

        // Reset values
        wait_to(2);
        check_all_zero("reset");
        wait_to(3);
        rstn = 1'b1;

        // 1) Plain CSRRS, response 3 cycles after issue
        wait_to(5);
        r = '{addr: 12'h300, cmd: 3'd2, data: 64'h8, pc: 64'h8000_0000};
        send_req(r, ki);
        wait_to(ki + 1);
        @(negedge clk);
        chk("wait_commit_stall", 192'(commit_stall), 192'(1));
        exp_wb(ki + 4, MNorm, 64'hABCD, 1'b0, 64'h0, 1'b0, 64'h0);
        do_resp(ki + 3, 64'hABCD, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        chk("done_commit_stall", 192'(commit_stall), 192'(0));

        // 2) Two replays: re-issue 5 cycles after each replay response, one writeback
        wait_to(cyc + 3);
        r = '{addr: 12'h341, cmd: 3'd1, data: 64'h1111, pc: 64'h8000_0010};
        send_req(r, ki);
        exp_iss(ki + 7, r);
        do_resp(ki + 2, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        chk("backoff_commit_stall", 192'(commit_stall), 192'(1));
        exp_iss(ki + 14, r);
        do_resp(ki + 9, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        exp_wb(ki + 17, MNorm, 64'h1234, 1'b0, 64'h0, 1'b1, 64'h8000_0100);
        do_resp(ki + 16, 64'h1234, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0100);
        wait_to(ki + 19);

        // 3) WFI stall held 20 cycles; result rdata forced to 0
        r = '{addr: 12'h105, cmd: 3'd4, data: 64'h0, pc: 64'h8000_0020};
        send_req(r, ki);
        exp_wb(ki + 23, MRdata | MXcpt, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        do_resp(ki + 2, 64'hDEAD, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        for (int c = ki + 3; c <= ki + 22; c++) begin
            wait_to(c);
            if (c == ki + 22) stall_in = 1'b0;
            @(negedge clk);
            chk("stall_commit_stall", 192'(commit_stall), 192'(1));
        end
        wait_to(ki + 25);

        // 4) No response: timeout exception after 64 WAIT cycles
        r = '{addr: 12'hC00, cmd: 3'd2, data: 64'h0, pc: 64'h8000_0030};
        send_req(r, ki);
        exp_wb(ki + 65, MXcpt | MCause, 64'h0, 1'b1, 64'h2, 1'b0, 64'h0);
        wait_to(ki + 64);
        @(negedge clk);
        chk("timeout_last_commit_stall", 192'(commit_stall), 192'(1));
        wait_to(ki + 67);

        // Exception wins over replay and stall in the same response
        r = '{addr: 12'h7C0, cmd: 3'd1, data: 64'h5A, pc: 64'h8000_0040};
        send_req(r, ki);
        exp_wb(ki + 3, MXcpt | MCause | MEvec, 64'h0, 1'b1, 64'h5, 1'b0, 64'h8000_0004);
        do_resp(ki + 2, 64'h55, 1'b1, 1'b1, 1'b1, 64'h5, 1'b1, 64'h8000_0004);
        stall_in = 1'b0;
        wait_to(ki + 5);

        // 5) Flush in WAIT: response consumed, no writeback, new request next cycle
        r = '{addr: 12'h340, cmd: 3'd1, data: 64'h77, pc: 64'h8000_0050};
        send_req(r, ki);
        wait_to(ki + 2);
        flush = 1'b1;
        wait_to(ki + 3);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_pend_commit_stall", 192'(commit_stall), 192'(1));
        do_resp(ki + 4, 64'h77, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        r = '{addr: 12'h342, cmd: 3'd2, data: 64'h0, pc: 64'h8000_0054};
        send_req(r, kj);
        chk("post_flush_accept_cycle", 192'(kj), 192'(ki + 6));
        exp_wb(kj + 3, MNorm, 64'h99, 1'b0, 64'h0, 1'b0, 64'h0);
        do_resp(kj + 2, 64'h99, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        wait_to(kj + 5);

        // Flush together with a request in IDLE: request ignored
        req_valid = 1'b1;
        flush = 1'b1;
        req = '{addr: 12'h001, cmd: 3'd1, data: 64'h1, pc: 64'h8000_0060};
        wait_to(cyc + 1);
        req_valid = 1'b0;
        flush = 1'b0;
        req = '0;
        wait_to(cyc + 6);

        // 6) Reset during BACKOFF: everything back to zero, no re-issue afterwards
        r = '{addr: 12'h180, cmd: 3'd1, data: 64'hF0, pc: 64'h8000_0070};
        send_req(r, ki);
        do_resp(ki + 2, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        wait_to(ki + 4);
        rstn = 1'b0;
        check_all_zero("midrst");
        wait_to(ki + 6);
        rstn = 1'b1;
        wait_to(ki + 20);

        chk("iss_q_drained", 192'(iss_q.size()), 192'(0));
        chk("wb_q_drained", 192'(wb_q.size()), 192'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
